// File: rtl/md5_pkg.sv
// md5_pkg: shared MD5 constants and helpers.
//   IV_A..IV_D : initial chaining values
//   K_TAB      : additive constants K[0..63]
//   S_TAB      : per-step left-rotate amounts S[0..63]
//   round_t    : which of the four nonlinear functions a step uses
//   bswap32    : byte reversal of a 32-bit word (little-endian <-> big-endian)
package md5_pkg;

  typedef enum logic [1:0] {
    RND_F = 2'd0,
    RND_G = 2'd1,
    RND_H = 2'd2,
    RND_I = 2'd3
  } round_t;

  localparam logic [31:0] IV_A = 32'h67452301;
  localparam logic [31:0] IV_B = 32'hefcdab89;
  localparam logic [31:0] IV_C = 32'h98badcfe;
  localparam logic [31:0] IV_D = 32'h10325476;

  localparam logic [31:0] K_TAB [64] = '{
    32'hd76aa478, 32'he8c7b756, 32'h242070db, 32'hc1bdceee,
    32'hf57c0faf, 32'h4787c62a, 32'ha8304613, 32'hfd469501,
    32'h698098d8, 32'h8b44f7af, 32'hffff5bb1, 32'h895cd7be,
    32'h6b901122, 32'hfd987193, 32'ha679438e, 32'h49b40821,
    32'hf61e2562, 32'hc040b340, 32'h265e5a51, 32'he9b6c7aa,
    32'hd62f105d, 32'h02441453, 32'hd8a1e681, 32'he7d3fbc8,
    32'h21e1cde6, 32'hc33707d6, 32'hf4d50d87, 32'h455a14ed,
    32'ha9e3e905, 32'hfcefa3f8, 32'h676f02d9, 32'h8d2a4c8a,
    32'hfffa3942, 32'h8771f681, 32'h6d9d6122, 32'hfde5380c,
    32'ha4beea44, 32'h4bdecfa9, 32'hf6bb4b60, 32'hbebfbc70,
    32'h289b7ec6, 32'heaa127fa, 32'hd4ef3085, 32'h04881d05,
    32'hd9d4d039, 32'he6db99e5, 32'h1fa27cf8, 32'hc4ac5665,
    32'hf4292244, 32'h432aff97, 32'hab9423a7, 32'hfc93a039,
    32'h655b59c3, 32'h8f0ccc92, 32'hffeff47d, 32'h85845dd1,
    32'h6fa87e4f, 32'hfe2ce6e0, 32'ha3014314, 32'h4e0811a1,
    32'hf7537e82, 32'hbd3af235, 32'h2ad7d2bb, 32'heb86d391
  };

  localparam logic [4:0] S_TAB [64] = '{
    5'd7, 5'd12, 5'd17, 5'd22, 5'd7, 5'd12, 5'd17, 5'd22,
    5'd7, 5'd12, 5'd17, 5'd22, 5'd7, 5'd12, 5'd17, 5'd22,
    5'd5, 5'd9,  5'd14, 5'd20, 5'd5, 5'd9,  5'd14, 5'd20,
    5'd5, 5'd9,  5'd14, 5'd20, 5'd5, 5'd9,  5'd14, 5'd20,
    5'd4, 5'd11, 5'd16, 5'd23, 5'd4, 5'd11, 5'd16, 5'd23,
    5'd4, 5'd11, 5'd16, 5'd23, 5'd4, 5'd11, 5'd16, 5'd23,
    5'd6, 5'd10, 5'd15, 5'd21, 5'd6, 5'd10, 5'd15, 5'd21,
    5'd6, 5'd10, 5'd15, 5'd21, 5'd6, 5'd10, 5'd15, 5'd21
  };

  function automatic logic [31:0] bswap32(input logic [31:0] w);
    return {w[7:0], w[15:8], w[23:16], w[31:24]};
  endfunction

endpackage

// File: rtl/md5_if.sv
// md5_if: message/digest bundle between the candidate generator (master)
// and the MD5 engine (slave).
//   message     : 64-bit message, right-aligned, most significant byte first
//   length      : message length in bits (low 3 bits ignored, capped at 8 bytes)
//   hash        : 128-bit digest, hash[127:120] = first digest byte
//   message_out : padded 512-bit block that produced hash, byte0 = [511:504]
interface md5_if;
  logic [63:0]  message;
  logic [63:0]  length;
  logic [127:0] hash;
  logic [511:0] message_out;

  modport master (output message, output length, input hash, input message_out);
  modport slave  (input message, input length, output hash, output message_out);
endinterface

// File: rtl/md5_step.sv
// md5_step: one combinational MD5 step.
//   a,b,c,d    : current chaining state
//   m          : message word M[g] already selected for this step
//   idx        : step index 0..63 (selects round function, K and S)
//   next_a..d  : state after the step
module md5_step
  import md5_pkg::*;
(
  input  logic [31:0] a,
  input  logic [31:0] b,
  input  logic [31:0] c,
  input  logic [31:0] d,
  input  logic [31:0] m,
  input  logic [5:0]  idx,
  output logic [31:0] next_a,
  output logic [31:0] next_b,
  output logic [31:0] next_c,
  output logic [31:0] next_d
);

  logic [31:0] f;
  logic [31:0] sum;
  logic [31:0] rot;
  logic [4:0]  s;

  always_comb begin
    f = '0;
    case (round_t'(idx[5:4]))
      RND_F:   f = (b & c) | (~b & d);
      RND_G:   f = (d & b) | (~d & c);
      RND_H:   f = b ^ c ^ d;
      RND_I:   f = c ^ (b | ~d);
      default: f = '0;
    endcase
    s      = S_TAB[idx];
    sum    = a + f + K_TAB[idx] + m;
    rot    = (sum << s) | (sum >> (6'd32 - {1'b0, s}));
    next_a = d;
    next_b = b + rot;
    next_c = b;
    next_d = c;
  end

endmodule

// File: rtl/md5_core.sv
// md5_core: free-running single-block MD5 hasher for messages up to 8 bytes.
// Every 65 clocks it loads and pads the current message, runs 64 steps at one
// step per clock and publishes the digest plus the block that produced it.
//   clk  : rising-edge clock
//   rst  : asynchronous active-high reset
//   bus  : md5_if.slave (message/length in, hash/message_out out)
module md5_core
  import md5_pkg::*;
(
  input  logic     clk,
  input  logic     rst,
  md5_if.slave     bus
);

  logic [6:0]   cnt,   cnt_d;
  logic [31:0]  a_q,   a_d;
  logic [31:0]  b_q,   b_d;
  logic [31:0]  c_q,   c_d;
  logic [31:0]  d_q,   d_d;
  logic [511:0] blk_q, blk_d;
  logic [127:0] hash_q, hash_d;
  logic [511:0] mo_q,  mo_d;

  logic [3:0]   n;
  logic [511:0] pad;
  logic         unused_len_bits;

  logic [5:0]   step_idx;
  logic [3:0]   g;
  logic [8:0]   word_base;
  logic [31:0]  m_word;
  logic [31:0]  na, nb, nc, nd;

  assign unused_len_bits = ^bus.length[2:0];

  // Byte count N = min(length>>3, 8); any bit at 64 or above saturates to 8.
  always_comb begin
    n   = (|bus.length[63:6]) ? 4'd8 : {1'b0, bus.length[5:3]};
    pad = '0;
    for (int unsigned j = 0; j < 56; j++) begin
      if (j < 32'(n)) begin
        pad[511 - 8*j -: 8] = bus.message[8*(32'(n) - 1 - j) +: 8];
      end else if (j == 32'(n)) begin
        pad[511 - 8*j -: 8] = 8'h80;
      end
    end
    pad[63:56] = {1'b0, n, 3'b000};
  end

  // cnt==64 wraps its low six bits to 0, so cnt-1 yields step 63 there.
  // The message index only depends on i mod 16, hence 4-bit arithmetic.
  always_comb begin
    step_idx = cnt[5:0] - 6'd1;
    g        = '0;
    case (round_t'(step_idx[5:4]))
      RND_F:   g = step_idx[3:0];
      RND_G:   g = step_idx[3:0] * 4'd5 + 4'd1;
      RND_H:   g = step_idx[3:0] * 4'd3 + 4'd5;
      RND_I:   g = step_idx[3:0] * 4'd7;
      default: g = '0;
    endcase
    word_base = 9'd511 - {g, 5'b00000};
    m_word    = bswap32(blk_q[word_base -: 32]);
  end

  md5_step u_step (
    .a      (a_q),
    .b      (b_q),
    .c      (c_q),
    .d      (d_q),
    .m      (m_word),
    .idx    (step_idx),
    .next_a (na),
    .next_b (nb),
    .next_c (nc),
    .next_d (nd)
  );

  always_comb begin
    cnt_d  = cnt;
    a_d    = a_q;
    b_d    = b_q;
    c_d    = c_q;
    d_d    = d_q;
    blk_d  = blk_q;
    hash_d = hash_q;
    mo_d   = mo_q;
    if (cnt == 7'd0) begin
      blk_d = pad;
      a_d   = IV_A;
      b_d   = IV_B;
      c_d   = IV_C;
      d_d   = IV_D;
      cnt_d = 7'd1;
    end else begin
      a_d   = na;
      b_d   = nb;
      c_d   = nc;
      d_d   = nd;
      cnt_d = cnt + 7'd1;
      if (cnt == 7'd64) begin
        cnt_d  = 7'd0;
        hash_d = {bswap32(IV_A + na), bswap32(IV_B + nb),
                  bswap32(IV_C + nc), bswap32(IV_D + nd)};
        mo_d   = blk_q;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt    <= '0;
      a_q    <= '0;
      b_q    <= '0;
      c_q    <= '0;
      d_q    <= '0;
      blk_q  <= '0;
      hash_q <= '0;
      mo_q   <= '0;
    end else begin
      cnt    <= cnt_d;
      a_q    <= a_d;
      b_q    <= b_d;
      c_q    <= c_d;
      d_q    <= d_d;
      blk_q  <= blk_d;
      hash_q <= hash_d;
      mo_q   <= mo_d;
    end
  end

  assign bus.hash        = hash_q;
  assign bus.message_out = mo_q;

endmodule

// File: tb/tb_md5_core.sv
module tb_md5_core;

  logic clk;
  logic rst;
  int   tests;
  int   fails;
  logic [31:0] kt [64];

  md5_if bus ();

  md5_core dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #3000000;
    $display("FAIL watchdog: simulation time limit reached, tests=%0d", tests);
    $fatal(1, "watchdog");
  end

  // ---------------- reference model (RFC 1321, from first principles) -------
  function automatic logic [511:0] ref_block(input logic [63:0] msg, input logic [63:0] len);
    logic [7:0]   by [64];
    logic [511:0] r;
    logic [63:0]  bits;
    longint unsigned nb;
    nb = len >> 3;
    if (nb > 8) nb = 8;
    for (int j = 0; j < 64; j++) by[j] = 8'h00;
    for (int j = 0; j < 64; j++) begin
      if (j < nb) begin
        bits  = msg >> (8 * (nb - 1 - j));
        by[j] = bits[7:0];
      end
    end
    by[nb] = 8'h80;
    bits = 8 * nb;
    for (int j = 0; j < 8; j++) by[56 + j] = 8'(bits >> (8 * j));
    r = '0;
    for (int j = 0; j < 64; j++) r[511 - 8*j -: 8] = by[j];
    return r;
  endfunction

  function automatic int unsigned shamt(input int i);
    int r;
    r = i / 16;
    case (r)
      0: case (i % 4) 0: return 7;  1: return 12; 2: return 17; default: return 22; endcase
      1: case (i % 4) 0: return 5;  1: return 9;  2: return 14; default: return 20; endcase
      2: case (i % 4) 0: return 4;  1: return 11; 2: return 16; default: return 23; endcase
      default: case (i % 4) 0: return 6; 1: return 10; 2: return 15; default: return 21; endcase
    endcase
  endfunction

  function automatic logic [127:0] ref_md5(input logic [511:0] blk);
    logic [31:0] m [16];
    logic [31:0] a, b, c, d, f, t, x, a0, b0, c0, d0;
    int unsigned g, s;
    for (int w = 0; w < 16; w++)
      m[w] = {blk[511 - 8*(4*w+3) -: 8], blk[511 - 8*(4*w+2) -: 8],
              blk[511 - 8*(4*w+1) -: 8], blk[511 - 8*(4*w) -: 8]};
    a0 = 32'h67452301; b0 = 32'hefcdab89; c0 = 32'h98badcfe; d0 = 32'h10325476;
    a = a0; b = b0; c = c0; d = d0;
    for (int i = 0; i < 64; i++) begin
      if (i < 16)      begin f = (b & c) | (~b & d); g = i;                end
      else if (i < 32) begin f = (d & b) | (~d & c); g = (5 * i + 1) % 16; end
      else if (i < 48) begin f = b ^ c ^ d;          g = (3 * i + 5) % 16; end
      else             begin f = c ^ (b | ~d);       g = (7 * i) % 16;     end
      s = shamt(i);
      x = a + f + kt[i] + m[g];
      t = d;
      d = c;
      c = b;
      b = b + ((x << s) | (x >> (32 - s)));
      a = t;
    end
    a = a0 + a; b = b0 + b; c = c0 + c; d = d0 + d;
    return {a[7:0], a[15:8], a[23:16], a[31:24], b[7:0], b[15:8], b[23:16], b[31:24],
            c[7:0], c[15:8], c[23:16], c[31:24], d[7:0], d[15:8], d[23:16], d[31:24]};
  endfunction

  task automatic init_k();
    real r;
    for (int i = 0; i < 64; i++) begin
      r = $sin(real'(i + 1));
      if (r < 0.0) r = -r;
      kt[i] = 32'(longint'($floor(r * 4294967296.0)));
    end
  endtask

  // ---------------- stimulus helpers (no checking inside) -------------------
  task automatic do_reset(input logic [63:0] msg, input logic [63:0] len);
    rst = 1'b1;
    bus.message = msg;
    bus.length  = len;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic wait_edges(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // ---------------- tests ---------------------------------------------------
  task automatic test_reset();
    rst = 1'b1;
    bus.message = {$urandom, $urandom};
    bus.length  = 64'd40;
    wait_edges(3);
    tests++;
    if (bus.hash !== 128'd0) begin
      fails++; $display("FAIL reset_hash: got %h want 0", bus.hash);
    end
    tests++;
    if (bus.message_out !== 512'd0) begin
      fails++; $display("FAIL reset_message_out: got %h want 0", bus.message_out);
    end
  endtask

  task automatic test_vectors();
    logic [63:0]  msgs [5];
    logic [63:0]  lens [5];
    logic [127:0] exps [5];
    logic [511:0] exp_mo;
    msgs[0] = 64'h74657374;    lens[0] = 64'd32; exps[0] = 128'h098f6bcd4621d373cade4e832627b4f6;
    msgs[1] = 64'hdeadbeef1234; lens[1] = 64'd0; exps[1] = 128'hd41d8cd98f00b204e9800998ecf8427e;
    msgs[2] = 64'h616263;      lens[2] = 64'd24; exps[2] = 128'h900150983cd24fb0d6963f7d28e17f72;
    msgs[3] = 64'h61;          lens[3] = 64'd8;  exps[3] = 128'h0cc175b9c0f1b6a831c399e269772661;
    msgs[4] = 64'h61;          lens[4] = 64'd13; exps[4] = 128'h0cc175b9c0f1b6a831c399e269772661;
    for (int v = 0; v < 5; v++) begin
      do_reset(msgs[v], lens[v]);
      wait_edges(65);
      tests++;
      if (bus.hash !== exps[v]) begin
        fails++; $display("FAIL vector%0d_hash: got %h want %h", v, bus.hash, exps[v]);
      end
      tests++;
      if (bus.message_out !== ref_block(msgs[v], lens[v])) begin
        fails++; $display("FAIL vector%0d_block: got %h want %h", v, bus.message_out,
                          ref_block(msgs[v], lens[v]));
      end
      if (v == 0) begin
        exp_mo = '0;
        exp_mo[511:472] = 40'h7465737480;
        exp_mo[63:56]   = 8'h20;
        tests++;
        if (bus.message_out !== exp_mo) begin
          fails++; $display("FAIL test_block_literal: got %h want %h", bus.message_out, exp_mo);
        end
      end
      if (v == 1) begin
        tests++;
        if (bus.message_out[511:504] !== 8'h80) begin
          fails++; $display("FAIL empty_pad_byte: got %h want 80", bus.message_out[511:504]);
        end
      end
    end
  endtask

  task automatic test_timing();
    logic [63:0]  m1, m2, l1;
    logic [127:0] h1, h2;
    int bad;
    m1 = {$urandom, $urandom};
    m2 = {$urandom, $urandom};
    l1 = 64'($urandom_range(0, 72));
    h1 = ref_md5(ref_block(m1, l1));
    h2 = ref_md5(ref_block(m2, l1));
    do_reset(m1, l1);
    bad = 0;
    for (int e = 1; e <= 64; e++) begin
      wait_edges(1);
      tests++;
      if (bus.hash !== 128'd0) begin
        fails++; bad++;
        if (bad < 4) $display("FAIL early_hash_edge%0d: got %h want 0", e, bus.hash);
      end
      if (e == 30) bus.message = m2;
    end
    wait_edges(1);
    tests++;
    if (bus.hash !== h1) begin
      fails++; $display("FAIL edge65_hash: got %h want %h", bus.hash, h1);
    end
    wait_edges(64);
    tests++;
    if (bus.hash !== h1) begin
      fails++; $display("FAIL hold_edge129: got %h want %h", bus.hash, h1);
    end
    wait_edges(1);
    tests++;
    if (bus.hash !== h2) begin
      fails++; $display("FAIL edge130_hash: got %h want %h", bus.hash, h2);
    end
    tests++;
    if (bus.message_out !== ref_block(m2, l1)) begin
      fails++; $display("FAIL edge130_block: got %h want %h", bus.message_out, ref_block(m2, l1));
    end
  endtask

  task automatic test_reset_mid();
    logic [63:0]  m, m3, l;
    logic [127:0] h, h3;
    m  = {$urandom, $urandom};
    m3 = {$urandom, $urandom};
    l  = 64'($urandom_range(8, 64));
    h  = ref_md5(ref_block(m, l));
    h3 = ref_md5(ref_block(m3, l));
    do_reset(m, l);
    wait_edges(105);
    tests++;
    if (bus.hash !== h) begin
      fails++; $display("FAIL pre_reset_hash: got %h want %h", bus.hash, h);
    end
    #2;
    rst = 1'b1;
    #1;
    tests++;
    if (bus.hash !== 128'd0) begin
      fails++; $display("FAIL async_reset_hash: got %h want 0", bus.hash);
    end
    tests++;
    if (bus.message_out !== 512'd0) begin
      fails++; $display("FAIL async_reset_block: got %h want 0", bus.message_out);
    end
    bus.message = m3;
    @(negedge clk);
    rst = 1'b0;
    wait_edges(64);
    tests++;
    if (bus.hash !== 128'd0) begin
      fails++; $display("FAIL restart_edge64: got %h want 0", bus.hash);
    end
    wait_edges(1);
    tests++;
    if (bus.hash !== h3) begin
      fails++; $display("FAIL restart_edge65: got %h want %h", bus.hash, h3);
    end
  endtask

  task automatic test_back_to_back();
    logic [63:0] m, l;
    m = {$urandom, $urandom};
    l = 64'($urandom_range(0, 79));
    do_reset(m, l);
    for (int k = 0; k < 10; k++) begin
      wait_edges(65);
      tests++;
      if (bus.hash !== ref_md5(ref_block(m, l))) begin
        fails++; $display("FAIL b2b%0d_hash: msg %h len %0d got %h want %h", k, m, l,
                          bus.hash, ref_md5(ref_block(m, l)));
      end
      tests++;
      if (bus.message_out !== ref_block(m, l)) begin
        fails++; $display("FAIL b2b%0d_block: got %h want %h", k, bus.message_out, ref_block(m, l));
      end
      m = {$urandom, $urandom};
      l = (k % 3 == 0) ? {$urandom, $urandom} : 64'($urandom_range(0, 79));
      bus.message = m;
      bus.length  = l;
    end
  endtask

  initial begin
    tests = 0;
    fails = 0;
    rst = 1'b1;
    bus.message = '0;
    bus.length  = '0;
    init_k();
    test_reset();
    test_vectors();
    test_timing();
    test_reset_mid();
    test_back_to_back();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
